// File: rtl/bfly_scale_round.sv
// bfly_scale_round: post-adder conditioning for the FFT butterfly.
//   Optional /2 scaling with rounding, saturation of the WIDTH+1-bit sums back
//   to WIDTH bits, frame tagging and per-frame saturation counting.
//   Latency: 2 cycles in_valid -> out_valid; no backpressure, 1 sample/cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid            in_re/in_im carry a sample this cycle
//   in_re, in_im        WIDTH+1-bit signed butterfly sums
//   scale_en            1 = divide by 2 with rounding; sampled at frame start
//   out_valid           output sample valid
//   out_re, out_im      WIDTH-bit signed conditioned sample (held when idle)
//   out_first/out_last  sample index 0 / FRAME_LEN-1 of the frame
//   ovf_cnt             saturated-sample count of the last completed frame
//   ovf_any             sticky: any sample saturated since reset
//
// Build option: define BFLY_CONVERGENT_ROUND_EN to round half-to-even when
// scaling; otherwise scaling rounds half up.

module bfly_scale_round #(
  parameter int WIDTH     = 24,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH:0]   in_re,
  input  logic [WIDTH:0]   in_im,
  input  logic             scale_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_first,
  output logic             out_last,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             ovf_any
);

  // Intermediate is one bit wider than the input so x+1 can never wrap.
  localparam int YW    = WIDTH + 2;
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Optional halving of one component with the selected rounding mode.
  function automatic logic signed [YW-1:0] scale_half(
    input logic [WIDTH:0] x_in,
    input logic           en
  );
    logic signed [YW-1:0] x;
    logic signed [YW-1:0] xp1;
    x   = signed'({x_in[WIDTH], x_in});
    xp1 = x + YW'(1);
    if (!en) begin
      return x;
    end
`ifdef BFLY_CONVERGENT_ROUND_EN
    // Exact half with an even quotient: truncate instead of rounding up.
    if (x[0] && !x[1]) begin
      return x >>> 1;
    end
`endif
    return xp1 >>> 1;
  endfunction

  // Frame position and the scale decision held for the whole frame.
  logic [IDX_W-1:0] idx;
  logic             frame_scale;
  logic             eff_scale;
  logic             idx_first;
  logic             idx_last;

  // Stage 1 registers.
  logic                  v1;
  logic                  first1;
  logic                  last1;
  logic signed [YW-1:0]  y1_re;
  logic signed [YW-1:0]  y1_im;

  // Stage 2 combinational saturation results.
  logic                  sat_re;
  logic                  sat_im;
  logic [WIDTH-1:0]      clip_re;
  logic [WIDTH-1:0]      clip_im;
  logic                  samp_sat;

  logic [CNT_W-1:0]      run_cnt;
  logic [CNT_W-1:0]      run_next;

  assign idx_first = (idx == '0);
  assign idx_last  = (idx == IDX_LAST);
  // The first sample of a frame uses scale_en directly: frame_scale only
  // becomes valid for the samples that follow it.
  assign eff_scale = idx_first ? scale_en : frame_scale;

  // Index, scale latch and stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      frame_scale <= 1'b0;
      v1          <= 1'b0;
      first1      <= 1'b0;
      last1       <= 1'b0;
      y1_re       <= '0;
      y1_im       <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        idx    <= idx_last ? '0 : idx + IDX_W'(1);
        first1 <= idx_first;
        last1  <= idx_last;
        y1_re  <= scale_half(in_re, eff_scale);
        y1_im  <= scale_half(in_im, eff_scale);
        if (idx_first) begin
          frame_scale <= scale_en;
        end
      end else begin
        first1 <= 1'b0;
        last1  <= 1'b0;
      end
    end
  end

  // Saturation: y fits in WIDTH bits iff its top YW-WIDTH+1 bits agree.
  always_comb begin
    sat_re  = (y1_re[YW-1:WIDTH-1] != {(YW-WIDTH+1){y1_re[YW-1]}});
    sat_im  = (y1_im[YW-1:WIDTH-1] != {(YW-WIDTH+1){y1_im[YW-1]}});
    clip_re = y1_re[WIDTH-1:0];
    clip_im = y1_im[WIDTH-1:0];
    if (sat_re) begin
      clip_re = y1_re[YW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    if (sat_im) begin
      clip_im = y1_im[YW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // A sample counts once even if both components clamp.
  assign samp_sat = v1 && (sat_re || sat_im);
  assign run_next = (samp_sat && (run_cnt != CNT_MAX)) ? run_cnt + CNT_W'(1) : run_cnt;

  // Stage 2 and saturation accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      run_cnt   <= '0;
      ovf_cnt   <= '0;
      ovf_any   <= 1'b0;
    end else begin
      out_valid <= v1;
      out_first <= v1 && first1;
      out_last  <= v1 && last1;
      if (v1) begin
        out_re <= clip_re;
        out_im <= clip_im;
        if (last1) begin
          // Publish the count including this final sample, start fresh.
          ovf_cnt <= run_next;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_next;
        end
      end
      if (samp_sat) begin
        ovf_any <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bfly_scale_round.sv
// Directed bench for bfly_scale_round: table of single-sample frames, a
// gapped full frame with mid-frame scale_en toggling, and a mid-frame reset.
module tb_bfly_scale_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [24:0] in_re;
  logic [24:0] in_im;
  logic        scale_en;
  logic        out_valid;
  logic [23:0] out_re;
  logic [23:0] out_im;
  logic        out_first;
  logic        out_last;
  logic [15:0] ovf_cnt;
  logic        ovf_any;

  int n_chk  = 0;
  int n_fail = 0;

  bfly_scale_round #(.WIDTH(24), .FRAME_LEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .scale_en(scale_en), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_first(out_first), .out_last(out_last), .ovf_cnt(ovf_cnt), .ovf_any(ovf_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        scale;
    logic [24:0] re;
    logic [24:0] im;
    logic [23:0] ere;
    logic [23:0] eim;
    logic        esat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_re"},    32'(out_re),    0);
    chk({tag, "_im"},    32'(out_im),    0);
    chk({tag, "_first"}, 32'(out_first), 0);
    chk({tag, "_last"},  32'(out_last),  0);
    chk({tag, "_cnt"},   32'(ovf_cnt),   0);
    chk({tag, "_any"},   32'(ovf_any),   0);
  endtask

  // One table vector as sample 0 of a frame, padded with 63 zero samples
  // (scale_en flipped, which must be ignored).
  task automatic run_vec(input vec_t v, input int id);
    for (int c = 0; c <= 64; c++) begin
      if (c == 0) begin
        in_valid = 1'b1; scale_en = v.scale; in_re = v.re; in_im = v.im;
      end else if (c < 64) begin
        in_valid = 1'b1; scale_en = ~v.scale; in_re = '0; in_im = '0;
      end else begin
        in_valid = 1'b0; scale_en = 1'b0; in_re = '0; in_im = '0;
      end
      step();
      if (c == 1) begin
        chk($sformatf("v%0d_valid", id), 32'(out_valid), 1);
        chk($sformatf("v%0d_first", id), 32'(out_first), 1);
        chk($sformatf("v%0d_last", id),  32'(out_last),  0);
        chk($sformatf("v%0d_re", id),    32'(out_re),    32'(v.ere));
        chk($sformatf("v%0d_im", id),    32'(out_im),    32'(v.eim));
      end
      if (c == 64) begin
        chk($sformatf("v%0d_lastflag", id), 32'(out_last), 1);
        chk($sformatf("v%0d_ovf_cnt", id),  32'(ovf_cnt),  32'(v.esat));
      end
    end
  endtask

  // Full frame with random gaps, scale_en toggling mid-frame, saturating
  // samples at 10/30/50, then sample 0 of the next frame unscaled.
  task automatic run_gapped();
    logic        hv [600];
    logic [23:0] e_re [600];
    logic [23:0] e_im [600];
    logic        e_f [600];
    logic        e_l [600];
    int          e_n [600];
    int          n;
    logic        gap;
    logic        done;
    logic        sat;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      gap = (n > 0) && (n < 65) && ($urandom_range(0, 2) == 0);
      if (n < 65 && !gap) begin
        sat = (n == 10) || (n == 30) || (n == 50);
        in_valid = 1'b1;
        scale_en = (n == 0) ? 1'b1 : (n == 64) ? 1'b0 : n[0];
        in_re = (n == 64) ? 25'h000000A : sat ? 25'h0FFFFFF : 25'h000000A;
        in_im = 25'h1FFFFF6;
        hv[c] = 1'b1;
        e_n[c] = n;
        e_re[c] = (n == 64) ? 24'h00000A : sat ? 24'h7FFFFF : 24'h000005;
        e_im[c] = (n == 64) ? 24'hFFFFF6 : 24'hFFFFFB;
        e_f[c] = (n == 0) || (n == 64);
        e_l[c] = (n == 63);
        n++;
      end else begin
        in_valid = 1'b0; scale_en = 1'b0; in_re = '0; in_im = '0;
        hv[c] = 1'b0;
      end
      step();
      if (c > 0) begin
        chk($sformatf("g%0d_valid", c), 32'(out_valid), 32'(hv[c-1]));
        if (hv[c-1]) begin
          chk($sformatf("g_s%0d_re", e_n[c-1]),    32'(out_re),    32'(e_re[c-1]));
          chk($sformatf("g_s%0d_im", e_n[c-1]),    32'(out_im),    32'(e_im[c-1]));
          chk($sformatf("g_s%0d_first", e_n[c-1]), 32'(out_first), 32'(e_f[c-1]));
          chk($sformatf("g_s%0d_last", e_n[c-1]),  32'(out_last),  32'(e_l[c-1]));
          if (e_n[c-1] >= 63) begin
            chk($sformatf("g_s%0d_ovf_cnt", e_n[c-1]), 32'(ovf_cnt), 3);
          end
          if (e_n[c-1] == 64) done = 1'b1;
        end
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL gapped_timeout: got %0d samples expected 65", n);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 25'h0000123, 25'h1FFF000, 24'h000123, 24'hFFF000, 1'b0};
`ifdef BFLY_CONVERGENT_ROUND_EN
    vecs[1] = '{1'b1, 25'h0000005, 25'h1FFFFFB, 24'h000002, 24'hFFFFFE, 1'b0};
`else
    vecs[1] = '{1'b1, 25'h0000005, 25'h1FFFFFB, 24'h000003, 24'hFFFFFE, 1'b0};
`endif
    vecs[2] = '{1'b1, 25'h0000007, 25'h0000006, 24'h000004, 24'h000003, 1'b0};
    vecs[3] = '{1'b0, 25'h0800000, 25'h17FFFFF, 24'h7FFFFF, 24'h800000, 1'b1};
    vecs[4] = '{1'b1, 25'h0FFFFFF, 25'h0000000, 24'h7FFFFF, 24'h000000, 1'b1};
    vecs[5] = '{1'b1, 25'h1000000, 25'h0000000, 24'h800000, 24'h000000, 1'b0};
    vecs[6] = '{1'b0, 25'h07FFFFF, 25'h1800000, 24'h7FFFFF, 24'h800000, 1'b0};
    vecs[7] = '{1'b1, 25'h0000003, 25'h1FFFFFF, 24'h000002, 24'h000000, 1'b0};
`ifdef BFLY_CONVERGENT_ROUND_EN
    vecs[8] = '{1'b1, 25'h0000001, 25'h1FFFFFD, 24'h000000, 24'hFFFFFE, 1'b0};
`else
    vecs[8] = '{1'b1, 25'h0000001, 25'h1FFFFFD, 24'h000001, 24'hFFFFFF, 1'b0};
`endif
    vecs[9] = '{1'b0, 25'h0FFFFFF, 25'h1000000, 24'h7FFFFF, 24'h800000, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; scale_en = 1'b0; in_re = '0; in_im = '0;
    #1;
    check_all_zero("reset");
    #21;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end
    chk("table_ovf_any", 32'(ovf_any), 1);

    run_gapped();

    // Mid-frame reset: 20 saturating samples, then reset while busy.
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; scale_en = 1'b0; in_re = 25'h0800000; in_im = '0;
      step();
    end
    chk("pre_reset_valid", 32'(out_valid), 1);
    in_valid = 1'b0; in_re = '0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #3;
    rst_n = 1'b1;
    step();
    for (int c = 0; c <= 65; c++) begin
      in_valid = (c < 64);
      scale_en = 1'b0;
      in_re = (c == 0) ? 25'h0000123 : 25'h0;
      in_im = '0;
      step();
      if (c == 1) begin
        chk("post_reset_valid", 32'(out_valid), 1);
        chk("post_reset_first", 32'(out_first), 1);
        chk("post_reset_re",    32'(out_re),    32'h123);
        chk("post_reset_cnt",   32'(ovf_cnt),   0);
        chk("post_reset_any",   32'(ovf_any),   0);
      end
      if (c == 63) chk("post_reset_last_early", 32'(out_last), 0);
      if (c == 64) begin
        chk("post_reset_last", 32'(out_last), 1);
        chk("post_reset_frame_cnt", 32'(ovf_cnt), 0);
      end
      if (c == 65) chk("post_reset_idle_re", 32'(out_re), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
